// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the MIPS-lite datapath.
// The master modport is the FSM side; the slave modport is the datapath side.
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             im_rdy;
    logic             dm_rdy;
    logic             ir_wr;
    logic             pc_wr;
    logic [2:0]       npc_op;
    logic             reg_wr;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             alu_src;
    logic [1:0]       ext_op;
    logic [2:0]       alu_op;
    logic             mem_wr;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, im_rdy, dm_rdy,
        output ir_wr, pc_wr, npc_op, reg_wr, reg_dst, wd_sel,
               alu_src, ext_op, alu_op, mem_wr, illegal, state, retired
    );

    modport slave (
        output instr, im_rdy, dm_rdy,
        input  ir_wr, pc_wr, npc_op, reg_wr, reg_dst, wd_sel,
               alu_src, ext_op, alu_op, mem_wr, illegal, state, retired
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-lite core: sequences one instruction
// through FETCH/DECODE/EXE/MEM/WB and counts retired instructions.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL, C_ILL
    } instr_class_t;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_retired;
    instr_class_t     w_cls;

    logic       w_ir_wr, w_pc_wr, w_reg_wr, w_mem_wr, w_illegal, w_alu_src;
    logic [2:0] w_npc_op, w_alu_op;
    logic [1:0] w_reg_dst, w_wd_sel, w_ext_op;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_cls = C_ILL;
        case (bus.instr[31:26])
            6'h00: begin
                case (bus.instr[5:0])
                    6'h21:   w_cls = C_ADDU;
                    6'h23:   w_cls = C_SUBU;
                    6'h08:   w_cls = C_JR;
                    default: w_cls = C_ILL;
                endcase
            end
            6'h0D:   w_cls = C_ORI;
            6'h23:   w_cls = C_LW;
            6'h2B:   w_cls = C_SW;
            6'h04:   w_cls = C_BEQ;
            6'h0F:   w_cls = C_LUI;
            6'h02:   w_cls = C_J;
            6'h03:   w_cls = C_JAL;
            default: w_cls = C_ILL;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_ir_wr      = 1'b0;
        w_pc_wr      = 1'b0;
        w_npc_op     = NPC_SEQ;
        w_reg_wr     = 1'b0;
        w_reg_dst    = 2'd0;
        w_wd_sel     = 2'd0;
        w_alu_src    = 1'b0;
        w_ext_op     = 2'd0;
        w_alu_op     = ALU_ADD;
        w_mem_wr     = 1'b0;
        w_illegal    = 1'b0;

        // ALU/extender selects stay stable from EXE until the instruction leaves WB.
        if (r_state == S_EXE || r_state == S_MEM || r_state == S_WB) begin
            case (w_cls)
                C_SUBU, C_BEQ: w_alu_op = ALU_SUB;
                C_ORI: begin
                    w_alu_op  = ALU_OR;
                    w_alu_src = 1'b1;
                end
                C_LUI: begin
                    w_alu_op  = ALU_OR;
                    w_alu_src = 1'b1;
                    w_ext_op  = 2'd2;
                end
                C_LW, C_SW: begin
                    w_alu_src = 1'b1;
                    w_ext_op  = 2'd1;
                end
                default: ;
            endcase
        end

        case (r_state)
            S_FETCH: begin
                w_ir_wr = bus.im_rdy;
                if (bus.im_rdy) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_state = S_FETCH;
                case (w_cls)
                    C_J: begin
                        w_pc_wr  = 1'b1;
                        w_npc_op = NPC_J;
                    end
                    C_JAL: begin
                        w_pc_wr   = 1'b1;
                        w_npc_op  = NPC_J;
                        w_reg_wr  = 1'b1;
                        w_reg_dst = 2'd2;
                        w_wd_sel  = 2'd2;
                    end
                    C_JR: begin
                        w_pc_wr  = 1'b1;
                        w_npc_op = NPC_JR;
                    end
                    C_ILL: begin
                        w_pc_wr   = 1'b1;
                        w_illegal = 1'b1;
                    end
                    default: w_next_state = S_EXE;
                endcase
            end
            S_EXE: begin
                case (w_cls)
                    C_BEQ: begin
                        w_pc_wr      = 1'b1;
                        w_npc_op     = NPC_BR;
                        w_next_state = S_FETCH;
                    end
                    C_LW, C_SW:                   w_next_state = S_MEM;
                    C_ADDU, C_SUBU, C_ORI, C_LUI: w_next_state = S_WB;
                    default:                      w_next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_mem_wr = (w_cls == C_SW) && bus.dm_rdy;
                if (bus.dm_rdy) begin
                    if (w_cls == C_SW) begin
                        w_pc_wr      = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_wr     = 1'b1;
                w_pc_wr      = 1'b1;
                w_reg_dst    = (w_cls == C_ADDU || w_cls == C_SUBU) ? 2'd1 : 2'd0;
                w_wd_sel     = (w_cls == C_LW) ? 2'd1 : 2'd0;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Strobes are suppressed during reset so an interrupted instruction writes nothing.
    assign bus.ir_wr   = w_ir_wr   & ~reset;
    assign bus.pc_wr   = w_pc_wr   & ~reset;
    assign bus.reg_wr  = w_reg_wr  & ~reset;
    assign bus.mem_wr  = w_mem_wr  & ~reset;
    assign bus.illegal = w_illegal & ~reset;
    assign bus.npc_op  = w_npc_op;
    assign bus.reg_dst = w_reg_dst;
    assign bus.wd_sel  = w_wd_sel;
    assign bus.alu_src = w_alu_src;
    assign bus.ext_op  = w_ext_op;
    assign bus.alu_op  = w_alu_op;
    assign bus.state   = r_state;
    assign bus.retired = r_retired;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_wr) r_retired <= r_retired + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class cycle by cycle
// against hand-computed strobe/state vectors.
module tb_mc_ctrl_fsm;
    localparam int CNT_W = 32;

    localparam logic [31:0] I_ADDU = 32'h0022_1821;  // addu $3,$1,$2
    localparam logic [31:0] I_SUBU = 32'h0022_2023;  // subu $4,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C25_0004;  // lw  $5,4($1)
    localparam logic [31:0] I_SW   = 32'hAC25_0008;  // sw  $5,8($1)
    localparam logic [31:0] I_JAL  = 32'h0C00_0C00;  // jal 0x0C00
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;  // opcode 0x3F
    localparam logic [31:0] I_ORI  = 32'h3426_00FF;  // ori $6,$1,0xFF
    localparam logic [31:0] I_LUI  = 32'h3C07_1234;  // lui $7,0x1234
    localparam logic [31:0] I_BEQ  = 32'h1022_0004;  // beq $1,$2,4
    localparam logic [31:0] I_J    = 32'h0800_0010;  // j 0x10
    localparam logic [31:0] I_JR   = 32'h03E0_0008;  // jr $31
    localparam logic [31:0] I_BADF = 32'h0000_003F;  // R-type, bad funct

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mc_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {state, ir_wr, pc_wr, npc_op, reg_wr, reg_dst, wd_sel, mem_wr, illegal}
    function automatic logic [14:0] ev(input logic [2:0] st, input logic ir, input logic pc,
                                       input logic [2:0] npc, input logic rw,
                                       input logic [1:0] rd, input logic [1:0] wd,
                                       input logic mw, input logic il);
        return {st, ir, pc, npc, rw, rd, wd, mw, il};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.state, bus.ir_wr, bus.pc_wr, bus.npc_op, bus.reg_wr,
                bus.reg_dst, bus.wd_sel, bus.mem_wr, bus.illegal};
    endfunction

    // One clock: check mid-cycle, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic [14:0] exp);
        @(negedge clk);
        check(tag, obs(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic cycd(input string tag, input logic [14:0] exp,
                        input logic src, input logic [1:0] ext, input logic [2:0] op);
        @(negedge clk);
        check(tag, obs(), exp);
        check({tag, "_dp"}, {bus.alu_src, bus.ext_op, bus.alu_op}, {src, ext, op});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ret(input string tag, input logic [CNT_W-1:0] exp);
        check(tag, bus.retired, exp);
    endtask

    localparam logic [14:0] E_FETCH  = 15'(ev(3'd0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
    localparam logic [14:0] E_DECODE = 15'(ev(3'd1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));

    initial begin
        reset      = 1'b1;
        bus.im_rdy = 1'b1;
        bus.dm_rdy = 1'b1;
        bus.instr  = I_ADDU;

        // reset two cycles, strobes forced low even with im_rdy=1
        cyc("rst0", ev(3'd0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
        cyc("rst1", ev(3'd0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
        chk_ret("rst_ret", '0);
        reset = 1'b0;

        // addu: 0,1,2,4
        cyc ("addu_f", E_FETCH);
        cyc ("addu_d", E_DECODE);
        cycd("addu_e", ev(3'd2, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0), 1'b0, 2'd0, 3'd0);
        cyc ("addu_w", ev(3'd4, 0, 1, 3'b000, 1, 2'd1, 2'd0, 0, 0));
        chk_ret("addu_ret", 32'd1);

        // lw with dm_rdy low three cycles in MEM
        bus.instr = I_LW;
        cyc ("lw_f", E_FETCH);
        cyc ("lw_d", E_DECODE);
        cycd("lw_e", ev(3'd2, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0), 1'b1, 2'd1, 3'd0);
        bus.dm_rdy = 1'b0;
        cycd("lw_m0", ev(3'd3, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0), 1'b1, 2'd1, 3'd0);
        cyc ("lw_m1", ev(3'd3, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0));
        cyc ("lw_m2", ev(3'd3, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0));
        bus.dm_rdy = 1'b1;
        cyc ("lw_m3", ev(3'd3, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0));
        cycd("lw_w", ev(3'd4, 0, 1, 3'b000, 1, 2'd0, 2'd1, 0, 0), 1'b1, 2'd1, 3'd0);
        chk_ret("lw_ret", 32'd2);

        // sw with zero-wait memory
        bus.instr = I_SW;
        cyc("sw_f", E_FETCH);
        cyc("sw_d", E_DECODE);
        cyc("sw_e", ev(3'd2, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0));
        cyc("sw_m", ev(3'd3, 0, 1, 3'b000, 0, 2'd0, 2'd0, 1, 0));
        chk_ret("sw_ret", 32'd3);

        // im_rdy low holds FETCH for one extra cycle, then jal
        bus.instr  = I_JAL;
        bus.im_rdy = 1'b0;
        cyc("jal_wait", ev(3'd0, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0));
        bus.im_rdy = 1'b1;
        cyc("jal_f", E_FETCH);
        cyc("jal_d", ev(3'd1, 0, 1, 3'b010, 1, 2'd2, 2'd2, 0, 0));
        chk_ret("jal_ret", 32'd4);

        // illegal opcode runs as a nop but retires
        bus.instr = I_BAD;
        cyc("bad_f", E_FETCH);
        cyc("bad_d", ev(3'd1, 0, 1, 3'b000, 0, 2'd0, 2'd0, 0, 1));
        chk_ret("bad_ret", 32'd5);

        // ori: zero-extended immediate, OR, rt destination
        bus.instr = I_ORI;
        cyc ("ori_f", E_FETCH);
        cyc ("ori_d", E_DECODE);
        cycd("ori_e", ev(3'd2, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0), 1'b1, 2'd0, 3'd2);
        cycd("ori_w", ev(3'd4, 0, 1, 3'b000, 1, 2'd0, 2'd0, 0, 0), 1'b1, 2'd0, 3'd2);

        // lui: imm<<16 through OR
        bus.instr = I_LUI;
        cyc ("lui_f", E_FETCH);
        cyc ("lui_d", E_DECODE);
        cycd("lui_e", ev(3'd2, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0), 1'b1, 2'd2, 3'd2);
        cyc ("lui_w", ev(3'd4, 0, 1, 3'b000, 1, 2'd0, 2'd0, 0, 0));

        // beq: three cycles, branch select in EXE
        bus.instr = I_BEQ;
        cyc ("beq_f", E_FETCH);
        cyc ("beq_d", E_DECODE);
        cycd("beq_e", ev(3'd2, 0, 1, 3'b001, 0, 2'd0, 2'd0, 0, 0), 1'b0, 2'd0, 3'd1);

        // subu: SUB and rd destination
        bus.instr = I_SUBU;
        cyc ("subu_f", E_FETCH);
        cyc ("subu_d", E_DECODE);
        cycd("subu_e", ev(3'd2, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0), 1'b0, 2'd0, 3'd1);
        cyc ("subu_w", ev(3'd4, 0, 1, 3'b000, 1, 2'd1, 2'd0, 0, 0));
        chk_ret("subu_ret", 32'd9);

        // j, jr, and an R-type with an unknown funct
        bus.instr = I_J;
        cyc("j_f", E_FETCH);
        cyc("j_d", ev(3'd1, 0, 1, 3'b010, 0, 2'd0, 2'd0, 0, 0));
        bus.instr = I_JR;
        cyc("jr_f", E_FETCH);
        cyc("jr_d", ev(3'd1, 0, 1, 3'b100, 0, 2'd0, 2'd0, 0, 0));
        bus.instr = I_BADF;
        cyc("badf_f", E_FETCH);
        cyc("badf_d", ev(3'd1, 0, 1, 3'b000, 0, 2'd0, 2'd0, 0, 1));
        chk_ret("badf_ret", 32'd12);

        // reset during MEM of sw abandons the store
        bus.instr = I_SW;
        cyc("rsw_f", E_FETCH);
        cyc("rsw_d", E_DECODE);
        cyc("rsw_e", ev(3'd2, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0));
        reset = 1'b1;
        cyc("rsw_m", ev(3'd3, 0, 0, 3'b000, 0, 2'd0, 2'd0, 0, 0));
        chk_ret("rsw_ret", '0);
        reset = 1'b0;
        cyc("rsw_after", E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
